pipe_skid_stage: RTL and testbench
==================================

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter: DATA_W, default 32, payload width in bits (>=1).
REQ-002 Parameter: CNT_W, default 16, stall-counter width in bits (>=2).
REQ-003 Port: clk  input  1  clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  reset, synchronous, active-high.
REQ-005 Port: flush  input  1  discard all held entries (pipeline squash).
REQ-006 Port: clr_stats  input  1  clear stall counter.
REQ-007 Port: in_valid  input  1  upstream offers in_data.
REQ-008 Port: in_ready  output  1  stage can accept; registered, not combinational from out_ready.
REQ-009 Port: in_data  input  DATA_W  upstream payload (e.g. packed EX-stage fields).
REQ-010 Port: out_valid  output  1  out_data holds a valid entry.
REQ-011 Port: out_ready  input  1  downstream consumes out_data this cycle.
REQ-012 Port: out_data  output  DATA_W  oldest held entry.
REQ-013 Port: occupancy  output  2  held entries, 0..2.
REQ-014 Port: stall_cycles  output  CNT_W  saturating count of back-pressure cycles.

Function
REQ-015 Storage: main register (drives out_data) plus one skid register; states EMPTY (0 entries), FULL (main only), SKID (main+skid).
REQ-016 Accept = in_valid && in_ready; transfer out = out_valid && out_ready.
REQ-017 out_valid = (state != EMPTY); in_ready = (state != SKID); occupancy = 0/1/2 for EMPTY/FULL/SKID.
REQ-018 EMPTY: accept -> FULL, main <= in_data; else stay EMPTY.
REQ-019 FULL: transfer and accept -> FULL, main <= in_data; transfer, no accept -> EMPTY; accept, no transfer -> SKID, skid <= in_data; neither -> FULL, main held.
REQ-020 SKID: transfer -> FULL, main <= skid; no transfer -> SKID, both held; no accept possible.
REQ-021 Latency: entry accepted in cycle N on empty stage appears at out_valid/out_data in cycle N+1.
REQ-022 Throughput: one entry per cycle sustained while out_ready stays high; no bubbles inserted.
REQ-023 Ordering strictly FIFO; no entry duplicated or dropped except by flush/reset.
REQ-024 out_data and held entries unchanged while out_valid && !out_ready.
REQ-025 flush: next state EMPTY, main and skid <= 0; input offered in flush cycle dropped; out_ready ignored that cycle.
REQ-026 stall_cycles increments by 1 each cycle with out_valid && !out_ready; saturates at 2^CNT_W-1 (no wrap).
REQ-027 clr_stats: stall_cycles <= 0 next cycle, overriding the increment in that cycle; flush does not clear it.
REQ-028 Simultaneous flush and clr_stats: both take effect independently.

Reset
REQ-029 reset has priority over flush and clr_stats.
REQ-030 On reset: state EMPTY, main=0, skid=0, out_valid=0, in_ready=1, occupancy=0, out_data=0, stall_cycles=0.
REQ-031 Reset mid-operation (FULL or SKID) discards all entries; first accept after reset deasserts behaves as from EMPTY.

Structure
REQ-032 Shared package holds the state enum (EMPTY, FULL, SKID) and default widths DATA_W=32, CNT_W=16.
REQ-033 Single module; saturating stall counter as sub-module sat_counter (params CNT_W; inputs inc, clr).
REQ-034 No combinational path from out_ready to in_ready; all outputs from flops.

Verification
REQ-035 Reset, then in_valid=1 data 0xA5A5_0001, out_ready=1 -> next cycle out_valid=1, out_data=0xA5A5_0001, occupancy=1.
REQ-036 Stream 0x1..0x8 back-to-back, out_ready=1 -> outputs 0x1..0x8 on consecutive cycles, in_ready always 1.
REQ-037 Hold out_ready=0, offer 0x10, 0x11, 0x12 -> 0x10 in main, 0x11 in skid, in_ready=0, 0x12 held upstream; release -> 0x10, 0x11, 0x12 in order.
REQ-038 In SKID state with 0x20/0x21 held, assert flush -> next cycle out_valid=0, occupancy=0, in_ready=1, out_data=0; 0x20/0x21 never delivered.
REQ-039 CNT_W=2, hold out_valid=1/out_ready=0 for 6 cycles -> stall_cycles 1,2,3,3,3,3; clr_stats pulse -> 0.
REQ-040 Assert reset while in SKID with stall_cycles=5 -> all outputs at REQ-030 values next cycle.

Source files
------------

// File: rtl/pipe_skid_stage_pkg.sv
// pipe_skid_stage_pkg: shared state encoding and default widths for the skid stage
package pipe_skid_stage_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_CNT_W  = 16;
    // Encoding equals the number of held entries, so occupancy is the state itself.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } skid_state_t;
endpackage

// File: rtl/pipe_skid_stage_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear
//   clk, reset : clock, sync active-high reset
//   inc        : count up by one this cycle (ignored at all-ones)
//   clr        : force to zero next cycle, overriding inc
//   count      : current value
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge clk) begin
        if (reset || clr)
            count <= '0;
        else if (inc && ~&count)
            count <= count + 1'b1;
    end
endmodule

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: two-entry registered skid buffer with flush and stall statistics
//   clk, reset              : clock, sync active-high reset
//   flush                   : drop all held entries and the input offered this cycle
//   clr_stats               : zero stall_cycles
//   in_valid/in_ready/in_data    : upstream handshake; in_ready is a flop decode
//   out_valid/out_ready/out_data : downstream handshake; out_data is the main register
//   occupancy               : held entries 0..2
//   stall_cycles            : saturating count of out_valid && !out_ready cycles
module pipe_skid_stage
    import pipe_skid_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              clr_stats,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cycles
);
    skid_state_t       state, state_nx;
    logic [DATA_W-1:0] main_q, main_nx, skid_q, skid_nx;
    logic              accept, xfer;

    // Handshake outputs decode only the state flop, so out_ready never reaches in_ready.
    assign out_valid = state != EMPTY;
    assign in_ready  = state != SKID;
    assign occupancy = state;
    assign out_data  = main_q;
    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state  <= state_nx;
            main_q <= main_nx;
            skid_q <= skid_nx;
        end
    end

    always_comb begin
        state_nx = state;
        main_nx  = main_q;
        skid_nx  = skid_q;
        if (flush) begin
            state_nx = EMPTY;
            main_nx  = '0;
            skid_nx  = '0;
        end else begin
            case (state)
                EMPTY: if (accept) begin
                    state_nx = FULL;
                    main_nx  = in_data;
                end
                FULL: begin
                    if (xfer && accept)
                        main_nx = in_data;
                    else if (xfer)
                        state_nx = EMPTY;
                    else if (accept) begin
                        state_nx = SKID;
                        skid_nx  = in_data;
                    end
                end
                SKID: if (xfer) begin
                    state_nx = FULL;
                    main_nx  = skid_q;
                end
                default: state_nx = EMPTY;
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall (
        .clk  (clk),
        .reset(reset),
        .inc  (out_valid && !out_ready),
        .clr  (clr_stats),
        .count(stall_cycles)
    );
endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: directed vector bench for pipe_skid_stage (wide and 2-bit counter builds)
module tb_pipe_skid_stage;
    logic        clk = 1'b0;
    logic        reset, flush, clr_stats, in_valid, out_ready;
    logic [31:0] in_data;
    logic        in_ready, out_valid, in_ready2, out_valid2;
    logic [31:0] out_data, out_data2;
    logic [1:0]  occupancy, occupancy2;
    logic [15:0] stall_cycles;
    logic [1:0]  stall_cycles2;
    int          passed = 0, total = 0;

    always #5 clk = ~clk;

    pipe_skid_stage #(.DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .flush(flush), .clr_stats(clr_stats),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .stall_cycles(stall_cycles)
    );

    pipe_skid_stage #(.DATA_W(32), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .flush(flush), .clr_stats(clr_stats),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .occupancy(occupancy2), .stall_cycles(stall_cycles2)
    );

    typedef struct {
        logic        fl, cl, iv;
        logic [31:0] id;
        logic        ordy, ov, ir, cod;
        logic [31:0] od;
        logic [1:0]  occ;
        logic [15:0] st;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic fl, logic cl, logic iv, logic [31:0] id, logic ordy,
                                logic ov, logic ir, logic cod, logic [31:0] od,
                                logic [1:0] occ, logic [15:0] st);
        vec_t v;
        v.fl = fl; v.cl = cl; v.iv = iv; v.id = id; v.ordy = ordy;
        v.ov = ov; v.ir = ir; v.cod = cod; v.od = od; v.occ = occ; v.st = st;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic step(input logic fl, input logic cl, input logic iv, input logic [31:0] id,
                        input logic ordy);
        flush = fl; clr_stats = cl; in_valid = iv; in_data = id; out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, " out_data"}, out_data, 32'd0);
        chk({tag, " occupancy"}, {30'd0, occupancy}, 32'd0);
        chk({tag, " stall"}, {16'd0, stall_cycles}, 32'd0);
        chk({tag, " stall2"}, {30'd0, stall_cycles2}, 32'd0);
    endtask

    initial begin
        vecs.push_back(mk(0,0,1,32'hA5A5_0001,1, 1,1,1,32'hA5A5_0001,1,0));
        for (int i = 1; i <= 8; i++)
            vecs.push_back(mk(0,0,1,i,1, 1,1,1,i,1,0));
        vecs.push_back(mk(0,0,0,0,1,     0,1,0,0,0,0));
        vecs.push_back(mk(0,0,1,32'h10,0, 1,1,1,32'h10,1,0));
        vecs.push_back(mk(0,0,1,32'h11,0, 1,0,1,32'h10,2,1));
        vecs.push_back(mk(0,0,1,32'h12,0, 1,0,1,32'h10,2,2));
        vecs.push_back(mk(0,0,1,32'h12,1, 1,1,1,32'h11,1,2));
        vecs.push_back(mk(0,0,1,32'h12,1, 1,1,1,32'h12,1,2));
        vecs.push_back(mk(0,0,0,0,1,      0,1,0,0,0,2));
        vecs.push_back(mk(0,0,1,32'h20,0, 1,1,1,32'h20,1,2));
        vecs.push_back(mk(0,0,1,32'h21,0, 1,0,1,32'h20,2,3));
        vecs.push_back(mk(1,0,1,32'h22,1, 0,1,1,0,0,3));
        vecs.push_back(mk(0,0,0,0,1,      0,1,1,0,0,3));
        vecs.push_back(mk(0,1,0,0,1,      0,1,1,0,0,0));
        vecs.push_back(mk(0,0,1,32'h30,0, 1,1,1,32'h30,1,0));
        vecs.push_back(mk(0,1,0,0,0,      1,1,1,32'h30,1,0));
        vecs.push_back(mk(0,0,0,0,0,      1,1,1,32'h30,1,1));
        vecs.push_back(mk(1,0,0,0,0,      0,1,1,0,0,2));
        vecs.push_back(mk(1,1,0,0,0,      0,1,1,0,0,0));

        reset = 1'b1;
        step(1, 1, 1, 32'hFFFF_FFFF, 1);
        chk_reset_state("reset");
        reset = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].fl, vecs[i].cl, vecs[i].iv, vecs[i].id, vecs[i].ordy);
            chk($sformatf("row%0d out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].ov});
            chk($sformatf("row%0d in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].ir});
            chk($sformatf("row%0d occupancy", i), {30'd0, occupancy}, {30'd0, vecs[i].occ});
            chk($sformatf("row%0d stall", i), {16'd0, stall_cycles}, {16'd0, vecs[i].st});
            chk($sformatf("row%0d stall2", i), {30'd0, stall_cycles2}, {30'd0, vecs[i].st[1:0]});
            chk($sformatf("row%0d occupancy2", i), {30'd0, occupancy2}, {30'd0, vecs[i].occ});
            chk($sformatf("row%0d handshake2", i), {30'd0, out_valid2, in_ready2},
                {30'd0, vecs[i].ov, vecs[i].ir});
            if (vecs[i].cod) begin
                chk($sformatf("row%0d out_data", i), out_data, vecs[i].od);
                chk($sformatf("row%0d out_data2", i), out_data2, vecs[i].od);
            end
        end

        reset = 1'b1;
        step(0, 0, 0, 0, 0);
        reset = 1'b0;
        step(0, 0, 1, 32'h40, 0);
        chk("sat load stall2", {30'd0, stall_cycles2}, 32'd0);
        for (int k = 1; k <= 6; k++) begin
            step(0, 0, 0, 0, 0);
            chk($sformatf("sat stall2 c%0d", k), {30'd0, stall_cycles2}, (k > 3) ? 32'd3 : k);
            chk($sformatf("sat stall c%0d", k), {16'd0, stall_cycles}, k);
        end
        step(0, 1, 0, 0, 0);
        chk("sat clr stall2", {30'd0, stall_cycles2}, 32'd0);
        chk("sat clr stall", {16'd0, stall_cycles}, 32'd0);
        chk("sat clr out_data", out_data, 32'h40);

        reset = 1'b1;
        step(0, 0, 0, 0, 0);
        reset = 1'b0;
        step(0, 0, 1, 32'h50, 0);
        step(0, 0, 1, 32'h51, 0);
        for (int k = 0; k < 4; k++) step(0, 0, 1, 32'h52, 0);
        chk("pre-reset stall", {16'd0, stall_cycles}, 32'd5);
        chk("pre-reset occupancy", {30'd0, occupancy}, 32'd2);
        chk("pre-reset out_data", out_data, 32'h50);
        reset = 1'b1;
        step(1, 0, 1, 32'h99, 0);
        chk_reset_state("mid reset");
        reset = 1'b0;
        step(0, 0, 1, 32'h60, 1);
        chk("post-reset out_valid", {31'd0, out_valid}, 32'd1);
        chk("post-reset out_data", out_data, 32'h60);
        chk("post-reset occupancy", {30'd0, occupancy}, 32'd1);
        step(0, 0, 0, 0, 1);
        chk("post-reset drain occupancy", {30'd0, occupancy}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
